// File: rtl/drops_pkg.sv
// ----------------------------------------------------------------------------
// drops_pkg
// Shared definitions for the drops game blocks. It holds the game-phase
// encoding that move_ctrl drives onto state_o and that the playfield/render
// logic decodes. It also holds the encoding of the move direction.
// ----------------------------------------------------------------------------
package drops_pkg;

    // Game phase. The encoding is visible on state_o, so keep the values stable.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_PLAY   = 2'b01,
        ST_FROZEN = 2'b10
    } game_state_e;

    // Value of dir_o for the last accepted move.
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/tick_gen.sv
// ----------------------------------------------------------------------------
// tick_gen
// Free-running prescaler that produces a 1-cycle strobe once every DIV clocks.
// The counter runs 0..DIV-1. The strobe is registered, so it goes high on the
// cycle the counter wraps back to 0. The first strobe appears DIV cycles after
// reset is released. The playfield drop timer reuses this module.
//
// Parameters
//   DIV     clocks per strobe (>= 2)
// Ports
//   clk_i   in   1   clock
//   rst_ni  in   1   asynchronous active-low reset
//   tick_o  out  1   1-cycle strobe, period DIV
// ----------------------------------------------------------------------------
module tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt    <= '0;
            tick_o <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt    <= '0;
            tick_o <= 1'b1;
        end else begin
            cnt    <= cnt + 1'b1;
            tick_o <= 1'b0;
        end
    end

endmodule

// File: rtl/move_ctrl.sv
// ----------------------------------------------------------------------------
// move_ctrl
// Sequencer and arbiter for the left/right debounced input path of the drops
// game. It has four jobs:
//   - It produces the sample strobe that the debouncer uses.
//   - It arbitrates the debouncer's left/right pulses.
//   - It enforces a cooldown after each accepted move.
//   - It owns the lane position and the IDLE/PLAY/FROZEN game phase.
//
// Parameters
//   SAMPLE_DIV  clocks per sample strobe (>= 2)
//   POS_W       width of the lane position
//   MAX_POS     rightmost lane; lane 0 is the leftmost lane
//   START_POS   lane loaded on reset and on each IDLE->PLAY transition
//   COOLDOWN    number of sample strobes after an accepted move during which
//               moves are dropped (0 disables the cooldown)
// Ports
//   clk_i      in   1      clock
//   rst_ni     in   1      asynchronous active-low reset
//   left_i     in   1      left pulse from the debouncer
//   right_i    in   1      right pulse from the debouncer
//   freeze_i   in   1      level: collision or game over from the playfield
//   restart_i  in   1      pulse: return to IDLE
//   e_inp_o    out  1      sample strobe to the debouncer
//   pos_o      out  POS_W  current lane
//   moved_o    out  1      1-cycle pulse when the position changes
//   dir_o      out  1      direction of the last accepted move (1 = right)
//   state_o    out  2      game phase (drops_pkg::game_state_e)
// ----------------------------------------------------------------------------
module move_ctrl
    import drops_pkg::*;
#(
    parameter int SAMPLE_DIV = 50000,
    parameter int POS_W      = 3,
    parameter int MAX_POS    = 7,
    parameter int START_POS  = 3,
    parameter int COOLDOWN   = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             left_i,
    input  logic             right_i,
    input  logic             freeze_i,
    input  logic             restart_i,
    output logic             e_inp_o,
    output logic [POS_W-1:0] pos_o,
    output logic             moved_o,
    output logic             dir_o,
    output logic [1:0]       state_o
);

    localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [POS_W-1:0] MAX_P   = POS_W'(MAX_POS);
    localparam logic [POS_W-1:0] START_P = POS_W'(START_POS);
    localparam logic [CD_W-1:0]  CD_LOAD = CD_W'(COOLDOWN);

    game_state_e     state;
    logic [CD_W-1:0] cooldown;
    logic            strobe;

    logic req_left;
    logic req_right;
    logic can_left;
    logic can_right;
    logic accept;
    logic go_idle;

    tick_gen #(
        .DIV (SAMPLE_DIV)
    ) u_tick_gen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .tick_o (strobe)
    );

    assign e_inp_o = strobe;
    assign state_o = state;

    // When left and right arrive in the same cycle, neither is a request. A
    // request at the edge lanes does not qualify as a move. In that case the
    // cooldown is not loaded and moved_o stays low.
    // The cooldown test uses the value before any strobe decrement in the
    // same cycle.
    always_comb begin
        req_left  = left_i & ~right_i;
        req_right = right_i & ~left_i;
        can_left  = req_left && (pos_o != '0);
        can_right = req_right && (pos_o != MAX_P);
        accept    = (state == ST_PLAY) && !restart_i && !freeze_i
                    && (cooldown == '0) && (can_left || can_right);
        go_idle   = restart_i && (state != ST_IDLE);
    end

    // Game-phase FSM, position register and cooldown counter.
    // restart_i wins over freeze_i in PLAY. The request that starts a game
    // only loads the start lane and does not move.
    // The cooldown counter is cleared whenever the FSM enters IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ST_IDLE;
            pos_o    <= START_P;
            moved_o  <= 1'b0;
            dir_o    <= DIR_LEFT;
            cooldown <= '0;
        end else begin
            moved_o <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (req_left || req_right) begin
                        state <= ST_PLAY;
                        pos_o <= START_P;
                    end
                end
                ST_PLAY: begin
                    if (restart_i) begin
                        state <= ST_IDLE;
                    end else if (freeze_i) begin
                        state <= ST_FROZEN;
                    end else if (accept) begin
                        moved_o <= 1'b1;
                        if (can_left) begin
                            pos_o <= pos_o - 1'b1;
                            dir_o <= DIR_LEFT;
                        end else begin
                            pos_o <= pos_o + 1'b1;
                            dir_o <= DIR_RIGHT;
                        end
                    end
                end
                ST_FROZEN: begin
                    if (restart_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (go_idle) begin
                cooldown <= '0;
            end else if (accept) begin
                cooldown <= CD_LOAD;
            end else if (strobe && (cooldown != '0)) begin
                cooldown <= cooldown - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_move_ctrl.sv
// ----------------------------------------------------------------------------
// tb_move_ctrl
// Self-checking bench for move_ctrl with SAMPLE_DIV=4, COOLDOWN=2, MAX_POS=7
// and START_POS=3.
// ----------------------------------------------------------------------------
module tb_move_ctrl;

    logic       clk;
    logic       rst_n;
    logic       left;
    logic       right;
    logic       freeze;
    logic       restart;
    logic       e_inp;
    logic [2:0] pos;
    logic       moved;
    logic       dir;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       e;
        logic [2:0] pos;
        logic       moved;
        logic       dir;
        logic [1:0] st;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    int m_cnt;
    bit m_strobe;
    int m_pos;
    bit m_dir;
    bit m_moved;
    int m_state;
    int m_cd;
    bit freeze_lvl;

    move_ctrl #(
        .SAMPLE_DIV (4),
        .POS_W      (3),
        .MAX_POS    (7),
        .START_POS  (3),
        .COOLDOWN   (2)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .left_i    (left),
        .right_i   (right),
        .freeze_i  (freeze),
        .restart_i (restart),
        .e_inp_o   (e_inp),
        .pos_o     (pos),
        .moved_o   (moved),
        .dir_o     (dir),
        .state_o   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h at t=%0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt    = 0;
        m_strobe = 0;
        m_pos    = 3;
        m_dir    = 0;
        m_moved  = 0;
        m_state  = 0;
        m_cd     = 0;
    endtask

    task automatic model_step(input bit l, input bit r, input bit f, input bit rs);
        int  old_cd     = m_cd;
        bit  old_strobe = m_strobe;
        bit  loaded     = 0;
        bit  cleared    = 0;
        bit  req        = (l != r);
        exp_t e;

        m_moved = 0;
        if (m_cnt == 3) begin
            m_cnt    = 0;
            m_strobe = 1;
        end else begin
            m_cnt    = m_cnt + 1;
            m_strobe = 0;
        end

        if (m_state == 0) begin
            if (req) begin
                m_state = 1;
                m_pos   = 3;
            end
        end else if (m_state == 1) begin
            if (rs) begin
                m_state = 0;
                cleared = 1;
            end else if (f) begin
                m_state = 2;
            end else if (req && old_cd == 0) begin
                if (l && m_pos > 0) begin
                    m_pos = m_pos - 1; m_dir = 0; m_moved = 1; loaded = 1;
                end else if (r && m_pos < 7) begin
                    m_pos = m_pos + 1; m_dir = 1; m_moved = 1; loaded = 1;
                end
            end
        end else begin
            if (rs) begin
                m_state = 0;
                cleared = 1;
            end
        end

        if (cleared)
            m_cd = 0;
        else if (loaded)
            m_cd = 2;
        else if (old_strobe && old_cd > 0)
            m_cd = old_cd - 1;

        e.e     = m_strobe;
        e.pos   = 3'(m_pos);
        e.moved = m_moved;
        e.dir   = m_dir;
        e.st    = 2'(m_state);
        exp_q.push_back(e);
    endtask

    // Drives one cycle of stimulus (called at a negedge) and compares the
    // DUT outputs against the expected values at the following negedge.
    task automatic apply_stimulus(input bit l, input bit r, input bit rs);
        exp_t e;
        left    = l;
        right   = r;
        restart = rs;
        freeze  = freeze_lvl;
        model_step(l, r, freeze_lvl, rs);
        @(posedge clk);
        @(negedge clk);
        check_output("queue_depth", 8'(exp_q.size()), 8'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output("e_inp", 8'(e_inp), 8'(e.e));
            check_output("pos",   8'(pos),   8'(e.pos));
            check_output("moved", 8'(moved), 8'(e.moved));
            check_output("dir",   8'(dir),   8'(e.dir));
            check_output("state", 8'(state), 8'(e.st));
        end
        left    = 1'b0;
        right   = 1'b0;
        restart = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        left       = 1'b0;
        right      = 1'b0;
        freeze     = 1'b0;
        restart    = 1'b0;
        freeze_lvl = 1'b0;
        model_reset();

        // Scenario 1: reset values, then strobes on cycles 4, 8 and 12
        @(negedge clk);
        @(negedge clk);
        check_output("rst_e_inp", 8'(e_inp), 8'd0);
        check_output("rst_pos",   8'(pos),   8'd3);
        check_output("rst_moved", 8'(moved), 8'd0);
        check_output("rst_dir",   8'(dir),   8'd0);
        check_output("rst_state", 8'(state), 8'd0);
        rst_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0);
            check_output("strobe_cycle", 8'(e_inp), ((c % 4) == 0) ? 8'd1 : 8'd0);
        end

        // Scenario 2: the start request only loads the start lane
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("s2_state", 8'(state), 8'd1);
        check_output("s2_nomove", 8'(moved), 8'd0);
        idle_cycles(2);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("s2_pos", 8'(pos), 8'd4);
        check_output("s2_moved", 8'(moved), 8'd1);
        check_output("s2_dir", 8'(dir), 8'd1);
        idle_cycles(1);
        check_output("s2_moved_pulse", 8'(moved), 8'd0);
        idle_cycles(10);

        // Scenario 3: walk to lane 0, edge request, cooldown drop
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0);
            idle_cycles(10);
        end
        check_output("s3_at_zero", 8'(pos), 8'd0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("s3_edge_pos", 8'(pos), 8'd0);
        check_output("s3_edge_moved", 8'(moved), 8'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("s3_first_right", 8'(pos), 8'd1);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("s3_cd_drop", 8'(pos), 8'd1);
        idle_cycles(10);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("s3_after_cd", 8'(pos), 8'd2);
        idle_cycles(10);

        // Scenario 4: both pulses together, then an immediate accepted move
        apply_stimulus(1'b1, 1'b1, 1'b0);
        check_output("s4_both_pos", 8'(pos), 8'd2);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("s4_cd_unchanged", 8'(pos), 8'd3);
        idle_cycles(10);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        idle_cycles(10);

        // Scenario 5: freeze, ignored pulses, restart, start from lane 3
        freeze_lvl = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("s5_frozen", 8'(state), 8'd2);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        idle_cycles(3);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("s5_frozen_pos", 8'(pos), 8'd4);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check_output("s5_restart", 8'(state), 8'd0);
        freeze_lvl = 1'b0;
        idle_cycles(2);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("s5_start_state", 8'(state), 8'd1);
        check_output("s5_start_pos", 8'(pos), 8'd3);

        // restart_i wins over freeze_i and clears the cooldown
        apply_stimulus(1'b0, 1'b1, 1'b0);
        freeze_lvl = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b1);
        freeze_lvl = 1'b0;
        check_output("prio_state", 8'(state), 8'd0);
        check_output("prio_pos_hold", 8'(pos), 8'd4);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("cd_cleared_move", 8'(pos), 8'd4);
        idle_cycles(10);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        idle_cycles(10);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("s6_pre_pos", 8'(pos), 8'd6);

        // Scenario 6: asynchronous reset mid-cooldown, between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check_output("arst_e_inp", 8'(e_inp), 8'd0);
        check_output("arst_pos",   8'(pos),   8'd3);
        check_output("arst_moved", 8'(moved), 8'd0);
        check_output("arst_dir",   8'(dir),   8'd0);
        check_output("arst_state", 8'(state), 8'd0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
